approx_add_arbiter: RTL and testbench

- Shares one 6-bit approximate adder between NREQ requesters using round-robin arbitration and per-port valid/ready handshakes.
- The adder uses the team's lower-part-OR scheme with P approximated LSBs, and its output is registered.
- Sits between multiple datapath clients and the single approximate adder resource, so clients need no adder instances of their own.

---
 rtl/approx_add_arbiter.sv | 164 ++++++++++++++++
 tb/tb_approx_add_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/approx_add_arbiter.sv
// approx_add_arbiter
//   Shares one registered 6-bit lower-part-OR approximate adder between NREQ
//   requesters. A round-robin arbiter picks one valid requester per cycle,
//   and the sum is captured in a single-entry result register with a
//   valid/ready handshake towards the consumer.
//
// Parameters
//   NREQ : number of requesters (2..8)
//   P    : number of approximated low bits (0..5), P=0 is an exact adder
//   IDW  : width of res_id, at least ceil(log2(NREQ))
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   req_valid  : per-requester operand valid
//   req_ready  : per-requester accept, at most one bit set
//   req_a      : operand A, requester i on bits [6i+5:6i]
//   req_b      : operand B, same slicing as req_a
//   res_valid  : result register holds a sum
//   res_ready  : consumer takes the result
//   res_data   : 7-bit sum, bit 6 is the carry-out
//   res_id     : requester that produced res_data
//
// Optional build macro APPROX_ADD_EXACT_MODE_EN
//   adds mode_exact (input, sampled on accept) selecting an exact A+B, and
//   res_exact (output) that records which mode produced res_data.
module approx_add_arbiter #(
    parameter int NREQ = 4,
    parameter int P    = 2,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [6*NREQ-1:0] req_a,
    input  logic [6*NREQ-1:0] req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [6:0]        res_data,
    output logic [IDW-1:0]    res_id
`ifdef APPROX_ADD_EXACT_MODE_EN
    ,
    input  logic              mode_exact,
    output logic              res_exact
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         state_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] rr_ptr_d;
    logic [6:0]     res_data_q;
    logic [IDW-1:0] res_id_q;
    logic [6:0]     sum_d;

    logic           cand_found;
    logic [IDW-1:0] cand_idx;
    logic           can_load;
    logic           grant_ok;
    logic [5:0]     a_sel;
    logic [5:0]     b_sel;
    logic [6:0]     approx_sum;

    // Index base+off, wrapped back into 0..NREQ-1.
    function automatic logic [IDW-1:0] ptr_plus(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // Round-robin search: walk offsets from the far end down to 0 so the
    // last hit written is the one closest to rr_ptr_q.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[ptr_plus(rr_ptr_q, k)]) begin
                cand_found = 1'b1;
                cand_idx   = ptr_plus(rr_ptr_q, k);
            end
        end
    end

    // A new operand pair may load when the register is free now or is
    // being emptied on this same edge.
    assign can_load = (state_q == EMPTY) | ((state_q == FULL) & res_ready);
    assign grant_ok = cand_found & can_load & ~rst;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ready
        assign req_ready[gi] = grant_ok && (cand_idx == IDW'(gi));
    end

    assign a_sel = req_a[6*int'(cand_idx) +: 6];
    assign b_sel = req_b[6*int'(cand_idx) +: 6];

    // Lower-part-OR adder. The low P bits are ORed; the AND of the top
    // approximated bit stands in for the carry into bit P, then bits P..5
    // ripple through the generate/propagate recurrence.
    always_comb begin
        logic carry;
        carry      = 1'b0;
        approx_sum = '0;
        for (int i = 0; i < 6; i++) begin
            if (i < P) begin
                approx_sum[i] = a_sel[i] | b_sel[i];
                carry         = (i == P - 1) ? (a_sel[i] & b_sel[i]) : 1'b0;
            end else begin
                approx_sum[i] = a_sel[i] ^ b_sel[i] ^ carry;
                carry         = (a_sel[i] & b_sel[i]) | ((a_sel[i] | b_sel[i]) & carry);
            end
        end
        approx_sum[6] = carry;
    end

`ifdef APPROX_ADD_EXACT_MODE_EN
    logic res_exact_q;
    assign sum_d = mode_exact ? ({1'b0, a_sel} + {1'b0, b_sel}) : approx_sum;
`else
    assign sum_d = approx_sum;
`endif

    assign rr_ptr_d = ptr_plus(cand_idx, 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= EMPTY;
            rr_ptr_q   <= '0;
            res_data_q <= '0;
            res_id_q   <= '0;
`ifdef APPROX_ADD_EXACT_MODE_EN
            res_exact_q <= 1'b0;
`endif
        end else begin
            if (grant_ok) begin
                // Covers both EMPTY->FULL and FULL drained-and-refilled.
                state_q    <= FULL;
                res_data_q <= sum_d;
                res_id_q   <= cand_idx;
                rr_ptr_q   <= rr_ptr_d;
`ifdef APPROX_ADD_EXACT_MODE_EN
                res_exact_q <= mode_exact;
`endif
            end else if ((state_q == FULL) && res_ready) begin
                state_q <= EMPTY;
            end
        end
    end

    assign res_valid = (state_q == FULL);
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
`ifdef APPROX_ADD_EXACT_MODE_EN
    assign res_exact = res_exact_q;
`endif

endmodule

// File: tb/tb_approx_add_arbiter.sv
// Scoreboard bench for approx_add_arbiter (NREQ=4, P=2, IDW=2).
// Stimulus pushes the hand-computed result for every request it issues;
// a monitor on the falling edge compares whatever the result register
// presents against the head of the queue and pops on a handshake.
module tb_approx_add_arbiter;

    localparam int NREQ = 4;
    localparam int P    = 2;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [6*NREQ-1:0] req_a;
    logic [6*NREQ-1:0] req_b;
    logic              res_valid;
    logic              res_ready;
    logic [6:0]        res_data;
    logic [IDW-1:0]    res_id;
`ifdef APPROX_ADD_EXACT_MODE_EN
    logic              mode_exact;
    logic              res_exact;
`endif

    typedef struct {
        logic [IDW-1:0] id;
        logic [6:0]     data;
        logic           exact;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    approx_add_arbiter #(.NREQ(NREQ), .P(P), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id)
`ifdef APPROX_ADD_EXACT_MODE_EN
        ,
        .mode_exact(mode_exact),
        .res_exact (res_exact)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input int data, input logic ex);
        exp_t e;
        e.id    = IDW'(id);
        e.data  = 7'(data);
        e.exact = ex;
        sb.push_back(e);
    endtask

    // Issue one request from requester i with nothing else pending; it must
    // be granted in the cycle it is raised and show up one cycle later.
    task automatic send(input int i, input int a, input int b, input int exp, input logic ex);
        req_a[6*i +: 6] = 6'(a);
        req_b[6*i +: 6] = 6'(b);
        req_valid[i]    = 1'b1;
        #1;
        chk("grant", 32'(req_ready), 32'(1 << i));
        push(i, exp, ex);
        cycle();
        req_valid[i] = 1'b0;
        chk("latency_valid", 32'(res_valid), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && sb.size() != 0; n++) begin
            cycle();
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: every cycle with res_valid up is compared against the queue
    // head, so held results during backpressure are checked each cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && res_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got id=%0d data=%0d, expected none", res_id, res_data);
                end else begin
                    chk("res_data", 32'(res_data), 32'(sb[0].data));
                    chk("res_id", 32'(res_id), 32'(sb[0].id));
`ifdef APPROX_ADD_EXACT_MODE_EN
                    chk("res_exact", 32'(res_exact), 32'(sb[0].exact));
`endif
                    if (res_ready) begin
                        $display("result id=%0d data=%0d", res_id, res_data);
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        res_ready = 1'b1;
`ifdef APPROX_ADD_EXACT_MODE_EN
        mode_exact = 1'b0;
`endif
        // Requester i offers A=4i, B=1: low bits never both set, sum = 4i+1.
        for (int i = 0; i < NREQ; i++) begin
            req_a[6*i +: 6] = 6'(4 * i);
            req_b[6*i +: 6] = 6'd1;
        end

        // Reset with every requester asking.
        repeat (2) begin
            cycle();
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_res_valid", 32'(res_valid), 32'd0);
            chk("rst_res_data", 32'(res_data), 32'd0);
            chk("rst_res_id", 32'(res_id), 32'd0);
        end
        rst = 1'b0;
        #1;

        // Fairness: all valid, consumer always ready, one grant per cycle.
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            push(k % 4, 4 * (k % 4) + 1, 1'b0);
            cycle();
        end
        req_valid = '0;
        drain();

        // Single request, approximate 3+1 -> 3.
        send(2, 3, 1, 3, 1'b0);
        drain();

        // Carry into bit P: 63+63 -> 127, then 5+6 -> 11.
        send(1, 63, 63, 127, 1'b0);
        send(1, 5, 6, 11, 1'b0);
        drain();

        // Backpressure: hold 10+20=30 for 5 cycles while requester 3 waits.
        res_ready = 1'b0;
        send(0, 10, 20, 30, 1'b0);
        req_a[18 +: 6] = 6'd7;
        req_b[18 +: 6] = 6'd9;
        req_valid[3]   = 1'b1;
        push(3, 15, 1'b0);
        repeat (5) begin
            chk("bp_req_ready", 32'(req_ready), 32'd0);
            cycle();
        end
        res_ready = 1'b1;
        #1;
        chk("bp_regrant", 32'(req_ready), 32'b1000);
        cycle();
        req_valid[3] = 1'b0;
        chk("bp_next_valid", 32'(res_valid), 32'd1);
        drain();

`ifdef APPROX_ADD_EXACT_MODE_EN
        mode_exact = 1'b1;
        send(2, 3, 1, 4, 1'b1);
        mode_exact = 1'b0;
        send(2, 3, 1, 3, 1'b0);
        drain();
`endif

        cycle();
        chk("idle_valid", 32'(res_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
